// File: rtl/regbank_decode_if.sv
// regbank_decode_if: instruction-side inputs and registered address/status outputs of regbank_decode.
interface regbank_decode_if #(
    parameter int LOW_W  = 2,
    parameter int BANK_W = 2
);
    logic                    valid_i;
    logic [1:0]              bank_op_i;
    logic [BANK_W-1:0]       bank_i;
    logic [LOW_W-1:0]        rs_lo_i;
    logic [LOW_W-1:0]        rd_lo_i;
    logic [BANK_W+LOW_W-1:0] rs_addr_o;
    logic [BANK_W+LOW_W-1:0] rd_addr_o;
    logic [BANK_W-1:0]       bank_o;
    logic                    valid_o;
    logic                    stack_full_o;
    logic                    stack_empty_o;
    logic                    err_o;
    modport master (
        output valid_i, bank_op_i, bank_i, rs_lo_i, rd_lo_i,
        input  rs_addr_o, rd_addr_o, bank_o, valid_o, stack_full_o, stack_empty_o, err_o
    );
    modport slave (
        input  valid_i, bank_op_i, bank_i, rs_lo_i, rd_lo_i,
        output rs_addr_o, rd_addr_o, bank_o, valid_o, stack_full_o, stack_empty_o, err_o
    );
endinterface

// File: rtl/regbank_decode.sv
// regbank_decode: registered {bank,low} address decoder with bank set/push/pop.
// Define REGDEC_STACK_EN to build the LIFO bank stack; otherwise push acts as set and pop as hold.
module regbank_decode #(
    parameter int LOW_W       = 2,
    parameter int BANK_W      = 2,
    parameter int STACK_DEPTH = 4
) (
    input logic clk,
    input logic rst_n,
    regbank_decode_if.slave bus
);
    localparam int AW = BANK_W + LOW_W;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [AW-1:0]     rs_q, rd_q;
    logic              valid_q;
`ifdef REGDEC_STACK_EN
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);
    logic [BANK_W-1:0] stack_q [STACK_DEPTH];
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              err_q, err_d, full, empty, push, pop, do_push, do_pop;
    always_comb begin
        full    = sp_q == SP_W'(STACK_DEPTH);
        empty   = sp_q == '0;
        push    = bus.valid_i && bus.bank_op_i == 2'b10;
        pop     = bus.valid_i && bus.bank_op_i == 2'b11;
        do_push = push && !full;
        do_pop  = pop && !empty;
        bank_d  = (bus.bank_op_i == 2'b01 || do_push) ? bus.bank_i
                : do_pop ? stack_q[IDX_W'(sp_q - SP_W'(1))] : bank_q;
        sp_d    = do_push ? sp_q + SP_W'(1) : do_pop ? sp_q - SP_W'(1) : sp_q;
        err_d   = err_q || (push && full) || (pop && empty);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end
    // Stack contents are don't-care after reset, so the storage carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) stack_q[IDX_W'(sp_q)] <= bank_q;
    end
    assign bus.stack_full_o  = full;
    assign bus.stack_empty_o = empty;
    assign bus.err_o         = err_q;
`else
    always_comb bank_d = ^bus.bank_op_i ? bus.bank_i : bank_q;
    assign bus.stack_full_o  = 1'b0;
    assign bus.stack_empty_o = 1'b1;
    assign bus.err_o         = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q  <= '0;
            rs_q    <= '0;
            rd_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.valid_i;
            if (bus.valid_i) begin
                bank_q <= bank_d;
                rs_q   <= {bank_d, bus.rs_lo_i};
                rd_q   <= {bank_d, bus.rd_lo_i};
            end
        end
    end
    assign bus.rs_addr_o = rs_q;
    assign bus.rd_addr_o = rd_q;
    assign bus.bank_o    = bank_q;
    assign bus.valid_o   = valid_q;
endmodule
